// File: rtl/cereal_pkg.sv
// Shared definitions for the cereal serial link (transmitter and receiver).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, default bit period, frame constants.
package cereal_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // 9600 baud from a 50 MHz system clock.
  localparam int CLKS_PER_BIT_DEFAULT = 5208;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/bit_sync.sv
// Generic 2-flop synchroniser for asynchronous single-bit inputs.
// Latency: 2 clk cycles from d to q.
// Backpressure: none (free-running).
// Ports: clk, reset (sync, active-high, loads RESET_VAL), d (async in), q (synchronised out).
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cereal_rx.sv
// UART-style receiver: 1 start, 8 data LSB first, 1 stop, idle high; one-byte holding register.
// Latency: valid/frame_err registered one cycle after the stop-bit mid-point sample.
// Backpressure: none on the line; an unacknowledged byte is overwritten and flagged by sticky overrun.
// Ports: sysclk, reset (sync, active-high), serial_in (raw line), data/valid/data_ack (byte handshake),
//        overrun (sticky), frame_err (1-cycle pulse), busy (frame in progress).
module cereal_rx
  import cereal_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 data_ack,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int               HALF      = CLKS_PER_BIT >> 1;
  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx;
  logic [1:0]           sync_fill;
  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shift;
  logic                 start_sample;
  logic                 data_sample;
  logic                 stop_sample;

  bit_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (sysclk),
    .reset(reset),
    .d    (serial_in),
    .q    (rx)
  );

  // The synchroniser's reset value is not a real observation of the line.
  // Only once both flops have clocked in the pin may WAIT_IDLE trust rx=1,
  // otherwise a line held low through reset would look briefly idle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_fill <= 2'b00;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // State register
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= WAIT_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      WAIT_IDLE: if (rx && sync_fill[1]) next_state = IDLE;
      IDLE:      if (!rx) next_state = START;
      START:     if (start_sample) next_state = rx ? IDLE : DATA;
      DATA:      if (data_sample && (idx == IDX_LAST)) next_state = STOP;
      STOP:      if (stop_sample) next_state = (rx == STOP_LEVEL) ? IDLE : WAIT_IDLE;
      default:   next_state = WAIT_IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    busy         = !((state == IDLE) || (state == WAIT_IDLE));
    start_sample = (state == START) && (cnt == HALF_LAST);
    data_sample  = (state == DATA)  && (cnt == BIT_LAST);
    stop_sample  = (state == STOP)  && (cnt == BIT_LAST);
  end

  // Baud counter: held at zero while waiting for a start edge, restarted at
  // every sample point so each following sample lands one bit period later.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == WAIT_IDLE) || (state == IDLE) ||
                 start_sample || data_sample || stop_sample) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      idx   <= '0;
      shift <= '0;
    end else if (start_sample) begin
      idx <= '0;
    end else if (data_sample) begin
      shift[idx] <= rx;
      idx        <= idx + 3'd1;
    end
  end

  // Holding register and flags. A good stop with no ack in the same cycle
  // onto a still-pending byte is an overrun; a same-cycle ack consumes the
  // old byte, so the new one is a clean hand-over.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_sample && (rx != STOP_LEVEL);
      if (stop_sample && (rx == STOP_LEVEL)) begin
        data    <= shift;
        valid   <= 1'b1;
        overrun <= valid && !data_ack;
      end else if (data_ack && valid) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cereal_rx.md
# cereal_rx

UART-style serial receiver: the receiving end of the `cereal` transmitter protocol (1 start bit low, 8 data bits LSB first, 1 stop bit high, idle high). It synchronises the raw line, validates the start bit, samples each bit at mid-period and presents each completed byte on a one-byte holding register with a valid/ack handshake. It replaces ad-hoc per-design bit sampling in front of the RAM and `cereal` blocks in the tweetboard designs.

## Interface
- `CLKS_PER_BIT`, 5208, sysclk cycles per bit (9600 baud at 50 MHz); legal range ≥ 4
- `sysclk`  in  1  system clock; sole clock domain
- `reset`  in  1  synchronous, active-high reset
- `serial_in`  in  1  raw asynchronous line, idle high
- `data`  out  8  last correctly framed byte; held until the next good byte
- `valid`  out  1  `data` holds an unacknowledged byte
- `data_ack`  in  1  single-cycle consumer acknowledge
- `overrun`  out  1  sticky: a good byte replaced an unacknowledged one
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `busy`  out  1  high in any state other than IDLE and WAIT_IDLE

## Operation
- Reset values: `data`=0, `valid`=0, `overrun`=0, `frame_err`=0, `busy`=0. The state is WAIT_IDLE. The synchroniser flops reset to 1.
- `serial_in` passes through a 2-flop synchroniser; `rx` denotes the synchronised line.
- HALF = CLKS_PER_BIT>>1. Baud counter width = clog2(CLKS_PER_BIT). Bit index is 3 bits.
- States:
  - WAIT_IDLE: stay until `rx`=1, then go to IDLE. This prevents false starts after reset, a break, or a line held low.
  - IDLE: when `rx`=0, go to START and clear the baud counter.
  - START: after HALF cycles, sample `rx`. If 0, go to DATA with bit index 0. If 1, treat it as a glitch and return to IDLE with no flags raised.
  - DATA: every CLKS_PER_BIT cycles, sample `rx` into shift bit[index]. After index 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx`.
    - If 1: load `data` from the shift register, set `valid`=1, and go to IDLE.
    - If 0: pulse `frame_err` for one cycle, leave `data` and `valid` unchanged, and go to WAIT_IDLE.
- Handshake:
  - `data_ack` while `valid`=1 clears `valid` and `overrun` on the next cycle.
  - `data_ack` while `valid`=0 is ignored.
- Overrun: a good stop sample while `valid`=1 and no `data_ack` in that cycle loads the new `data` and sets `overrun`=1.
- Simultaneous good stop sample and `data_ack`: the new byte loads, `valid` stays 1, and `overrun` is 0.
- Reset mid-frame: abandon the byte and return to reset values. No flags are raised.

## Timing
- Pin to `rx` latency: 2 cycles.
- Let t0 be the first IDLE cycle in which `rx`=0.
- Sample points:
  - Start sample: t0+HALF.
  - Data bit i (i = 0..7): t0+HALF+(i+1)·CLKS_PER_BIT.
  - Stop sample: t0+HALF+9·CLKS_PER_BIT.
- `valid` (or `frame_err`) is registered high at t0+HALF+9·CLKS_PER_BIT+1. `data` changes in the same cycle.
- `busy` rises at t0+1 and falls in the cycle `valid` or `frame_err` asserts.
- Back-to-back frames: IDLE is re-entered at the stop mid-point, so the next start edge is accepted with no gap. Tolerated baud mismatch is ±4 % cumulative across 10 bits.

## Structure
- Shared package `cereal_pkg` holds:
  - the state encoding (WAIT_IDLE, IDLE, START, DATA, STOP)
  - default `CLKS_PER_BIT`
  - frame constants (DATA_BITS=8, STOP_LEVEL=1)
- `cereal` uses the same package entries.
- Sub-module `bit_sync`: a generic 2-flop synchroniser with a parameterised reset value. It is instantiated here and is reusable for the button inputs.

## Test plan
(bench `CLKS_PER_BIT`=16, HALF=8)
- Reset, hold line high, send 0x41 → `valid` high 153 cycles after the synchronised start, `data`=0x41, `frame_err`=0. Ack → `valid`=0 next cycle.
- Low glitch of 4 cycles on an idle line → return to IDLE. `valid`, `frame_err` and `busy` end at 0, and `data` is unchanged.
- Send 0x55 with the stop bit forced low → one-cycle `frame_err`, `data` keeps its prior value. Then hold low 40 cycles, raise, send 0x0F → `data`=0x0F.
- Send 0x12 then 0x34 back-to-back with no ack → `data`=0x34, `valid`=1, `overrun`=1. Ack → both clear.
- Pulse `data_ack` in exactly the cycle 0x34's stop is sampled, with 0x12 pending → `data`=0x34, `valid`=1, `overrun`=0.
- Assert `reset` during data bit 3 of 0xAA, then hold the line low after release → no start is accepted until the line goes high. The next 0xC3 is received correctly.
